// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-stage controller.
//   memState_t              : access FSM states (IDLE, ACCESS)
//   PCSRC_*                 : PC-select mux encodings driven on out_PCSrc
//   DEFAULT_TIMEOUT_CYCLES  : default access timeout (used with MEM_TIMEOUT_EN)
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// Access-timeout counter for the memory-stage controller.
// Counts falling edges while enabled; `expired` flags the enabled cycle whose
// closing edge brings the count to LIMIT.
// Ports:
//   clk     : pipeline clock (state updates on the falling edge)
//   reset   : synchronous, active-low
//   clear   : return the count to zero at the next edge
//   enable  : count this cycle (ACCESS cycle without mem_ready)
//   expired : this cycle is the one that reaches LIMIT
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(negedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_controller.sv
// Memory-stage controller fed by the EX/MEM pipeline register.
// Resolves BEQ/BNE/J into a PC redirect plus flush, and runs a ready-handshaked
// data-memory access for loads/stores, stalling the pipeline while it waits.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES and raise the sticky out_MemError flag.
// Ports:
//   clk, reset             : falling-edge clock, synchronous active-low reset
//   in_*                   : EX/MEM register outputs (control bits, ALU result,
//                            store data, jump/branch targets)
//   mem_req/we/addr/wdata  : data-memory request side
//   mem_rdata, mem_ready   : data-memory response side
//   out_ReadData           : load data to MEM/WB
//   out_Stall              : freeze PC and pipeline registers
//   out_PCSrc/TargetAddress: PC-select and redirect address
//   out_Flush              : flush younger pipeline registers
//   out_MemError           : sticky access-timeout flag
module mem_stage_controller
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_Zero,
  input  logic        in_CtrlJump,
  input  logic        in_CtrlMemRead,
  input  logic        in_CtrlMemWrite,
  input  logic        in_CtrlBranchEquals,
  input  logic        in_CtrlBranchNotEquals,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_ReadData2,
  input  logic [31:0] in_JumpAddress,
  input  logic [31:0] in_BranchAddress,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] out_ReadData,
  output logic        out_Stall,
  output logic [1:0]  out_PCSrc,
  output logic [31:0] out_TargetAddress,
  output logic        out_Flush,
  output logic        out_MemError
);

  memState_t   state;
  memState_t   nextState;
  logic        access;
  logic        taken;
  logic        expired;
  logic        readComplete;
  logic [31:0] readDataReg;

  assign access    = in_CtrlMemRead | in_CtrlMemWrite;
  assign taken     = (in_CtrlBranchEquals & in_Zero) | (in_CtrlBranchNotEquals & ~in_Zero);
  assign mem_we    = in_CtrlMemWrite;
  assign mem_addr  = in_ALUResult;
  assign mem_wdata = in_ReadData2;

  // State register
  always_ff @(negedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (access && !mem_ready) nextState = ACCESS;
      ACCESS:  if (mem_ready || expired) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic; everything handshake/redirect related is gated off in reset
  always_comb begin
    mem_req           = 1'b0;
    out_Stall         = 1'b0;
    out_PCSrc         = PCSRC_SEQ;
    out_TargetAddress = '0;
    out_Flush         = 1'b0;
    readComplete      = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    mem_req = access;
        // An expiring access drops its request in the expiry cycle itself
        ACCESS:  mem_req = ~expired;
        default: mem_req = 1'b0;
      endcase
      out_Stall    = mem_req & ~mem_ready;
      // Write wins when both read and write are set
      readComplete = mem_req & mem_ready & ~in_CtrlMemWrite;
      if (in_CtrlJump) begin
        out_PCSrc         = PCSRC_JUMP;
        out_TargetAddress = in_JumpAddress;
      end else if (taken) begin
        out_PCSrc         = PCSRC_BRANCH;
        out_TargetAddress = in_BranchAddress;
      end
      // A redirecting memory instruction flushes only in its completion cycle
      out_Flush = (out_PCSrc != PCSRC_SEQ) & ~out_Stall;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      readDataReg <= '0;
    end else if (readComplete) begin
      readDataReg <= mem_rdata;
    end
  end

  assign out_ReadData = readComplete ? mem_rdata : readDataReg;

`ifdef MEM_TIMEOUT_EN
  logic counting;
  logic memErrorReg;

  assign counting = (state == ACCESS) & ~mem_ready;

  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (~counting),
    .enable (counting),
    .expired(expired)
  );

  always_ff @(negedge clk) begin
    if (!reset) begin
      memErrorReg <= 1'b0;
    end else if (expired) begin
      memErrorReg <= 1'b1;
    end
  end

  assign out_MemError = memErrorReg;
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
  assign expired          = 1'b0;
  assign out_MemError     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_controller.sv
// Self-checking bench for mem_stage_controller (instantiated with
// TIMEOUT_CYCLES = 4). DUT state changes on the falling edge; inputs are driven
// just after it and outputs are sampled on the rising edge.
module tb_mem_stage_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_Zero, in_CtrlJump, in_CtrlMemRead, in_CtrlMemWrite;
  logic        in_CtrlBranchEquals, in_CtrlBranchNotEquals;
  logic [31:0] in_ALUResult, in_ReadData2, in_JumpAddress, in_BranchAddress;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, out_Stall, out_Flush, out_MemError;
  logic [31:0] mem_addr, mem_wdata, out_ReadData, out_TargetAddress;
  logic [1:0]  out_PCSrc;

  int nCheck = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  mem_stage_controller #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_Zero               (in_Zero),
    .in_CtrlJump           (in_CtrlJump),
    .in_CtrlMemRead        (in_CtrlMemRead),
    .in_CtrlMemWrite       (in_CtrlMemWrite),
    .in_CtrlBranchEquals   (in_CtrlBranchEquals),
    .in_CtrlBranchNotEquals(in_CtrlBranchNotEquals),
    .in_ALUResult          (in_ALUResult),
    .in_ReadData2          (in_ReadData2),
    .in_JumpAddress        (in_JumpAddress),
    .in_BranchAddress      (in_BranchAddress),
    .mem_rdata             (mem_rdata),
    .mem_ready             (mem_ready),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .out_ReadData          (out_ReadData),
    .out_Stall             (out_Stall),
    .out_PCSrc             (out_PCSrc),
    .out_TargetAddress     (out_TargetAddress),
    .out_Flush             (out_Flush),
    .out_MemError          (out_MemError)
  );

  typedef struct {
    logic        jump, beq, bne, zero, rd, wr, ready;
    logic [31:0] alu, rd2, jaddr, baddr, rdata;
    logic        expReq, expWe, expStall, expFlush;
    logic [1:0]  expPc;
    logic [31:0] expTgt, expRd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCheck++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearIn();
    in_Zero = 0; in_CtrlJump = 0; in_CtrlMemRead = 0; in_CtrlMemWrite = 0;
    in_CtrlBranchEquals = 0; in_CtrlBranchNotEquals = 0;
    in_ALUResult = '0; in_ReadData2 = '0; in_JumpAddress = '0; in_BranchAddress = '0;
    mem_rdata = '0; mem_ready = 0;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic sample();
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] expRd;
    int          stallCnt;
    int          complCnt;

    //                jmp beq bne zr rd wr rdy alu        rd2        jaddr      baddr      rdata         req we st fl pc     tgt        rd
    vecs[0]  = '{0,0,1,0, 0,0,1, 32'h0,     32'h0,     32'h0,     32'h40,    32'h0,        0,0,0,1, 2'b01, 32'h40,    32'h0};
    vecs[1]  = '{0,0,1,1, 0,0,1, 32'h0,     32'h0,     32'h0,     32'h40,    32'h0,        0,0,0,0, 2'b00, 32'h0,     32'h0};
    vecs[2]  = '{0,1,0,1, 0,0,1, 32'h0,     32'h0,     32'h0,     32'h80,    32'h0,        0,0,0,1, 2'b01, 32'h80,    32'h0};
    vecs[3]  = '{0,1,0,0, 0,0,1, 32'h0,     32'h0,     32'h0,     32'h80,    32'h0,        0,0,0,0, 2'b00, 32'h0,     32'h0};
    vecs[4]  = '{1,1,0,1, 0,0,1, 32'h0,     32'h0,     32'h1000,  32'h80,    32'h0,        0,0,0,1, 2'b10, 32'h1000,  32'h0};
    vecs[5]  = '{0,0,0,0, 1,0,1, 32'h10,    32'h0,     32'h0,     32'h0,     32'hDEADBEEF, 1,0,0,0, 2'b00, 32'h0,     32'hDEADBEEF};
    vecs[6]  = '{0,0,0,0, 0,0,0, 32'h0,     32'h0,     32'h0,     32'h0,     32'h12345678, 0,0,0,0, 2'b00, 32'h0,     32'hDEADBEEF};
    vecs[7]  = '{0,0,0,0, 0,1,1, 32'h20,    32'h55,    32'h0,     32'h0,     32'hAAAA5555, 1,1,0,0, 2'b00, 32'h0,     32'hDEADBEEF};
    vecs[8]  = '{0,0,0,0, 1,1,1, 32'h24,    32'h66,    32'h0,     32'h0,     32'h13572468, 1,1,0,0, 2'b00, 32'h0,     32'hDEADBEEF};
    vecs[9]  = '{0,0,1,0, 1,0,1, 32'h28,    32'h0,     32'h0,     32'h44,    32'h0BADF00D, 1,0,0,1, 2'b01, 32'h44,    32'h0BADF00D};
    vecs[10] = '{1,0,1,1, 0,0,0, 32'h0,     32'h0,     32'h2000,  32'h44,    32'h0,        0,0,0,1, 2'b10, 32'h2000,  32'h0BADF00D};
    vecs[11] = '{0,1,1,0, 0,0,0, 32'h0,     32'h0,     32'h0,     32'h48,    32'h0,        0,0,0,1, 2'b01, 32'h48,    32'h0BADF00D};

    // Reset held 3 cycles with a pending load and a jump: everything gated off
    clearIn();
    reset = 0;
    in_CtrlMemRead = 1; in_CtrlJump = 1; in_JumpAddress = 32'h300;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("rst%0d.req", c),   32'(mem_req), 32'h0);
      chk($sformatf("rst%0d.stall", c), 32'(out_Stall), 32'h0);
      chk($sformatf("rst%0d.pcsrc", c), 32'(out_PCSrc), 32'h0);
      chk($sformatf("rst%0d.flush", c), 32'(out_Flush), 32'h0);
      chk($sformatf("rst%0d.tgt", c),   out_TargetAddress, 32'h0);
      nextCycle();
    end
    reset = 1;
    clearIn();
    sample();
    chk("rel.err",  32'(out_MemError), 32'h0);
    chk("rel.rd",   out_ReadData, 32'h0);
    chk("rel.req",  32'(mem_req), 32'h0);
    chk("rel.addr", mem_addr, 32'h0);
    nextCycle();

    // Single-cycle vectors (memory always ready or no access)
    for (int i = 0; i < 12; i++) begin
      in_CtrlJump = vecs[i].jump; in_CtrlBranchEquals = vecs[i].beq;
      in_CtrlBranchNotEquals = vecs[i].bne; in_Zero = vecs[i].zero;
      in_CtrlMemRead = vecs[i].rd; in_CtrlMemWrite = vecs[i].wr; mem_ready = vecs[i].ready;
      in_ALUResult = vecs[i].alu; in_ReadData2 = vecs[i].rd2;
      in_JumpAddress = vecs[i].jaddr; in_BranchAddress = vecs[i].baddr; mem_rdata = vecs[i].rdata;
      sample();
      chk($sformatf("v%0d.req", i),   32'(mem_req), 32'(vecs[i].expReq));
      chk($sformatf("v%0d.we", i),    32'(mem_we), 32'(vecs[i].expWe));
      chk($sformatf("v%0d.stall", i), 32'(out_Stall), 32'(vecs[i].expStall));
      chk($sformatf("v%0d.flush", i), 32'(out_Flush), 32'(vecs[i].expFlush));
      chk($sformatf("v%0d.pcsrc", i), 32'(out_PCSrc), 32'(vecs[i].expPc));
      chk($sformatf("v%0d.tgt", i),   out_TargetAddress, vecs[i].expTgt);
      chk($sformatf("v%0d.rd", i),    out_ReadData, vecs[i].expRd);
      chk($sformatf("v%0d.addr", i),  mem_addr, vecs[i].alu);
      chk($sformatf("v%0d.wdata", i), mem_wdata, vecs[i].rd2);
      nextCycle();
    end
    expRd = 32'h0BADF00D;
    clearIn();

    // Store with 3 wait cycles: exactly 3 stall cycles, stable request, one completion
    stallCnt = 0; complCnt = 0;
    in_CtrlMemWrite = 1; in_ALUResult = 32'h20; in_ReadData2 = 32'h55;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      mem_rdata = 32'h5000_0000 + 32'(k);
      sample();
      if (out_Stall) stallCnt++;
      if (mem_req && mem_ready) complCnt++;
      chk($sformatf("st%0d.req", k),   32'(mem_req), 32'h1);
      chk($sformatf("st%0d.we", k),    32'(mem_we), 32'h1);
      chk($sformatf("st%0d.addr", k),  mem_addr, 32'h20);
      chk($sformatf("st%0d.wdata", k), mem_wdata, 32'h55);
      chk($sformatf("st%0d.rd", k),    out_ReadData, expRd);
      nextCycle();
    end
    chk("st.stallCycles", 32'(stallCnt), 32'd3);
    chk("st.completions", 32'(complCnt), 32'd1);
    clearIn();
    sample();
    chk("st.after.req", 32'(mem_req), 32'h0);
    nextCycle();

    // Load with 2 wait cycles plus a jump: redirect held off until completion
    in_CtrlMemRead = 1; in_ALUResult = 32'h30; in_CtrlJump = 1; in_JumpAddress = 32'h2400;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      mem_rdata = (k == 2) ? 32'hCAFEF00D : 32'h1111_0000 + 32'(k);
      sample();
      chk($sformatf("ldj%0d.stall", k), 32'(out_Stall), (k == 2) ? 32'h0 : 32'h1);
      chk($sformatf("ldj%0d.flush", k), 32'(out_Flush), (k == 2) ? 32'h1 : 32'h0);
      chk($sformatf("ldj%0d.pcsrc", k), 32'(out_PCSrc), 32'h2);
      chk($sformatf("ldj%0d.rd", k),    out_ReadData, (k == 2) ? 32'hCAFEF00D : expRd);
      nextCycle();
    end
    expRd = 32'hCAFEF00D;
    clearIn();
    sample();
    chk("ldj.after.rd",    out_ReadData, expRd);
    chk("ldj.after.pcsrc", 32'(out_PCSrc), 32'h0);
    nextCycle();

`ifdef MEM_TIMEOUT_EN
    // Memory never ready: 4 stall cycles, then request drops and error latches
    in_CtrlMemRead = 1; in_ALUResult = 32'h50; mem_rdata = 32'h77777777;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk($sformatf("to%0d.req", k),   32'(mem_req), (k == 4) ? 32'h0 : 32'h1);
      chk($sformatf("to%0d.stall", k), 32'(out_Stall), (k == 4) ? 32'h0 : 32'h1);
      chk($sformatf("to%0d.err", k),   32'(out_MemError), 32'h0);
      nextCycle();
    end
    clearIn();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("to.sticky%0d.err", k), 32'(out_MemError), 32'h1);
      chk($sformatf("to.sticky%0d.rd", k),  out_ReadData, expRd);
      nextCycle();
    end
    reset = 0;
    nextCycle();
    reset = 1;
    expRd = 32'h0;
    sample();
    chk("to.rst.err", 32'(out_MemError), 32'h0);
    nextCycle();
    // Ready arrives in the expiry cycle: completion wins, no error
    in_CtrlMemRead = 1; in_ALUResult = 32'h54;
    for (int k = 0; k < 5; k++) begin
      mem_ready = (k == 4);
      mem_rdata = (k == 4) ? 32'h99999999 : 32'h0;
      sample();
      chk($sformatf("tw%0d.req", k),   32'(mem_req), 32'h1);
      chk($sformatf("tw%0d.stall", k), 32'(out_Stall), (k == 4) ? 32'h0 : 32'h1);
      nextCycle();
    end
    expRd = 32'h99999999;
    clearIn();
    sample();
    chk("tw.after.err", 32'(out_MemError), 32'h0);
    chk("tw.after.rd",  out_ReadData, expRd);
    nextCycle();
`else
    // No timeout build: the access waits indefinitely without error
    in_CtrlMemRead = 1; in_ALUResult = 32'h50; mem_rdata = 32'h77777777;
    stallCnt = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (out_Stall) stallCnt++;
      nextCycle();
    end
    chk("wait.stallCycles", 32'(stallCnt), 32'd20);
    chk("wait.err", 32'(out_MemError), 32'h0);
    mem_ready = 1; mem_rdata = 32'h99999999;
    sample();
    chk("wait.done.stall", 32'(out_Stall), 32'h0);
    chk("wait.done.rd", out_ReadData, 32'h99999999);
    nextCycle();
    expRd = 32'h99999999;
    clearIn();
`endif

    // Reset in the middle of a waiting access abandons it
    in_CtrlMemRead = 1; in_ALUResult = 32'h60; mem_rdata = 32'hABCDABCD;
    sample();
    chk("mid0.stall", 32'(out_Stall), 32'h1);
    nextCycle();
    sample();
    chk("mid1.stall", 32'(out_Stall), 32'h1);
    nextCycle();
    reset = 0;
    sample();
    chk("mid.rst.req",   32'(mem_req), 32'h0);
    chk("mid.rst.stall", 32'(out_Stall), 32'h0);
    nextCycle();
    reset = 1;
    clearIn();
    sample();
    chk("mid.after.req", 32'(mem_req), 32'h0);
    chk("mid.after.rd",  out_ReadData, 32'h0);
    chk("mid.after.err", 32'(out_MemError), 32'h0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nCheck, nFail);
    $finish;
  end

endmodule
